// File: rtl/mem_write_checker.sv
// Store-sequence checker: watches the data-memory write port and latches a sticky
// PASS / FAIL / TIMEOUT verdict for an ordered list of expected (addr, data) stores.
//
//  state   | meaning
//  IDLE    | waiting for arm; stores ignored, counters held at 0
//  RUN     | checking stores against entry match_idx, counting cycles
//  PASS    | every expected store seen in order (sticky)
//  FAIL    | stray store seen; fail_code/fail_addr/fail_data hold it (sticky)
//  TIMEOUT | TIMEOUT_CYC run cycles elapsed without a verdict (sticky)
module mem_write_checker #(
    parameter int                          ADDR_W      = 32,
    parameter int                          DATA_W      = 32,
    parameter int                          NUM_EXP     = 1,
    parameter logic [NUM_EXP*ADDR_W-1:0]   EXP_ADDR    = 32'd84,
    parameter logic [NUM_EXP*DATA_W-1:0]   EXP_DATA    = 32'd7,
    parameter logic [ADDR_W-1:0]           IGN_LO      = 32'd80,
    parameter logic [ADDR_W-1:0]           IGN_HI      = 32'd80,
    parameter int                          TIMEOUT_CYC = 1024,
    parameter int                          CNT_W       = 16,
    localparam int                         IDX_W       = $clog2(NUM_EXP + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [IDX_W-1:0]  match_idx,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  ign_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TIMEOUT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EXP - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    state_t              state, state_n;
    logic [IDX_W-1:0]    match_n;
    logic [CNT_W-1:0]    cyc_n, ign_n;
    logic [1:0]          code_n;
    logic [ADDR_W-1:0]   fa_n, exp_a;
    logic [DATA_W-1:0]   fd_n, exp_d;
    logic                in_win;

    // Mux out the entry currently expected; match_idx never selects past the table in RUN.
    always_comb begin
        exp_a = '0;
        exp_d = '0;
        for (int i = 0; i < NUM_EXP; i++) begin
            if (match_idx == IDX_W'(i)) begin
                exp_a = EXP_ADDR[i*ADDR_W +: ADDR_W];
                exp_d = EXP_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_win = (dataadr >= IGN_LO) && (dataadr <= IGN_HI);

    always_comb begin
        state_n = state;
        match_n = match_idx;
        cyc_n   = cyc_cnt;
        ign_n   = ign_cnt;
        code_n  = fail_code;
        fa_n    = fail_addr;
        fd_n    = fail_data;
        case (state)
            IDLE: begin
                if (arm) state_n = RUN;
            end
            RUN: begin
                if (cyc_cnt != '1) cyc_n = cyc_cnt + 1'b1;
                if (memwrite) begin
                    if (dataadr == exp_a && writedata == exp_d) begin
                        match_n = match_idx + 1'b1;
                        if (match_idx == LAST_IDX) state_n = PASS;
                    end else if (in_win) begin
                        if (ign_cnt != '1) ign_n = ign_cnt + 1'b1;
                    end else begin
                        state_n = FAIL;
                        code_n  = (dataadr == exp_a) ? 2'd1 : 2'd2;
                        fa_n    = dataadr;
                        fd_n    = writedata;
                    end
                end
                // A store verdict on the same edge wins over the timeout.
                if (state_n == RUN && TIMEOUT_CYC != 0 && cyc_cnt == TO_LAST) begin
                    state_n = TIMEOUT;
                    code_n  = 2'd3;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            match_idx <= '0;
            cyc_cnt   <= '0;
            ign_cnt   <= '0;
            fail_code <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            state     <= state_n;
            match_idx <= match_n;
            cyc_cnt   <= cyc_n;
            ign_cnt   <= ign_n;
            fail_code <= code_n;
            fail_addr <= fa_n;
            fail_data <= fd_n;
        end
    end

    assign done = (state == PASS) || (state == FAIL) || (state == TIMEOUT);
    assign pass = (state == PASS);

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: default, three-entry and short-timeout instances
// share stimulus; only the instance under test is released from reset at a time.
module tb_mem_write_checker;

    logic        clk = 1'b0;
    logic        rst_def = 1'b0, rst_seq = 1'b0, rst_to = 1'b0;
    logic        arm = 1'b0, memwrite = 1'b0;
    logic [31:0] dataadr = '0, writedata = '0;

    logic        d_done, d_pass, s_done, s_pass, t_done, t_pass;
    logic [1:0]  d_code, s_code, t_code;
    logic [0:0]  d_idx, t_idx;
    logic [1:0]  s_idx;
    logic [15:0] d_cyc, d_ign, s_cyc, s_ign, t_cyc, t_ign;
    logic [31:0] d_fa, d_fd, s_fa, s_fd, t_fa, t_fd;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_write_checker u_def (
        .clk(clk), .reset(rst_def), .arm(arm), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata),
        .done(d_done), .pass(d_pass), .fail_code(d_code), .match_idx(d_idx),
        .cyc_cnt(d_cyc), .ign_cnt(d_ign), .fail_addr(d_fa), .fail_data(d_fd)
    );

    mem_write_checker #(
        .NUM_EXP(3),
        .EXP_ADDR({32'd108, 32'd104, 32'd100}),
        .EXP_DATA({32'd3, 32'd2, 32'd1})
    ) u_seq (
        .clk(clk), .reset(rst_seq), .arm(arm), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata),
        .done(s_done), .pass(s_pass), .fail_code(s_code), .match_idx(s_idx),
        .cyc_cnt(s_cyc), .ign_cnt(s_ign), .fail_addr(s_fa), .fail_data(s_fd)
    );

    mem_write_checker #(.TIMEOUT_CYC(20)) u_to (
        .clk(clk), .reset(rst_to), .arm(arm), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata),
        .done(t_done), .pass(t_pass), .fail_code(t_code), .match_idx(t_idx),
        .cyc_cnt(t_cyc), .ign_cnt(t_ign), .fail_addr(t_fa), .fail_data(t_fd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_done", d_done, 0);
        chk("rst_pass", d_pass, 0);
        chk("rst_code", d_code, 0);
        chk("rst_idx", d_idx, 0);
        chk("rst_cyc", d_cyc, 0);
        chk("rst_faddr", d_fa, 0);

        // T1: scratch stores tolerated, then the expected store
        rst_def = 1'b1;
        store(32'd88, 32'd7);
        chk("idle_store_ignored", d_done, 0);
        chk("idle_cyc_hold", d_cyc, 0);
        do_arm();
        chk("t1_armed_done", d_done, 0);
        store(32'd80, 32'd11);
        store(32'd80, 32'd22);
        store(32'd80, 32'd33);
        chk("t1_ign_mid", d_ign, 3);
        chk("t1_pass_pre", d_pass, 0);
        store(32'd84, 32'd7);
        chk("t1_pass", d_pass, 1);
        chk("t1_done", d_done, 1);
        chk("t1_ign", d_ign, 3);
        chk("t1_idx", d_idx, 1);
        chk("t1_code", d_code, 0);
        chk("t1_cyc", d_cyc, 4);
        store(32'd88, 32'd7);
        do_arm();
        chk("t1_sticky_pass", d_pass, 1);
        chk("t1_sticky_code", d_code, 0);
        chk("t1_cyc_frozen", d_cyc, 4);

        // T2: right address, wrong data
        rst_def = 1'b0;
        tick();
        rst_def = 1'b1;
        chk("t2_rst_done", d_done, 0);
        chk("t2_rst_ign", d_ign, 0);
        chk("t2_rst_idx", d_idx, 0);
        do_arm();
        store(32'd84, 32'd6);
        chk("t2_done", d_done, 1);
        chk("t2_pass", d_pass, 0);
        chk("t2_code", d_code, 1);
        chk("t2_faddr", d_fa, 84);
        chk("t2_fdata", d_fd, 6);
        store(32'd84, 32'd7);
        chk("t2_late_idx", d_idx, 0);
        chk("t2_late_pass", d_pass, 0);
        chk("t2_late_code", d_code, 1);

        // T3: stray address; idle bus activity without memwrite is ignored
        rst_def = 1'b0;
        tick();
        rst_def = 1'b1;
        do_arm();
        dataadr = 32'd88;
        writedata = 32'd5;
        tick();
        chk("t3_nowrite", d_done, 0);
        store(32'd88, 32'd7);
        chk("t3_code", d_code, 2);
        chk("t3_faddr", d_fa, 88);
        chk("t3_fdata", d_fd, 7);
        chk("t3_pass", d_pass, 0);
        rst_def = 1'b0;

        // T4: three-entry sequence in order, scratch store interleaved
        rst_seq = 1'b1;
        tick();
        do_arm();
        store(32'd100, 32'd1);
        chk("t4_idx1", s_idx, 1);
        store(32'd80, 32'd9);
        chk("t4_ign", s_ign, 1);
        store(32'd104, 32'd2);
        chk("t4_idx2", s_idx, 2);
        chk("t4_done_mid", s_done, 0);
        store(32'd108, 32'd3);
        chk("t4_pass", s_pass, 1);
        chk("t4_idx3", s_idx, 3);
        chk("t4_code", s_code, 0);

        // T4b: later entry out of order
        rst_seq = 1'b0;
        tick();
        rst_seq = 1'b1;
        do_arm();
        store(32'd104, 32'd2);
        chk("t4b_code", s_code, 2);
        chk("t4b_idx", s_idx, 0);
        chk("t4b_faddr", s_fa, 104);
        chk("t4b_done", s_done, 1);

        // T6: reset mid-sequence, pre-arm stores ignored, re-arm
        rst_seq = 1'b0;
        tick();
        rst_seq = 1'b1;
        do_arm();
        store(32'd100, 32'd1);
        store(32'd104, 32'd2);
        chk("t6_idx_pre", s_idx, 2);
        rst_seq = 1'b0;
        tick();
        chk("t6_rst_idx", s_idx, 0);
        chk("t6_rst_cyc", s_cyc, 0);
        chk("t6_rst_done", s_done, 0);
        rst_seq = 1'b1;
        store(32'd100, 32'd1);
        chk("t6_prearm_idx", s_idx, 0);
        chk("t6_prearm_done", s_done, 0);
        do_arm();
        store(32'd100, 32'd1);
        store(32'd104, 32'd2);
        store(32'd108, 32'd3);
        chk("t6_pass", s_pass, 1);
        chk("t6_idx", s_idx, 3);
        rst_seq = 1'b0;

        // T5: timeout on the 20th run edge
        rst_to = 1'b1;
        tick();
        do_arm();
        repeat (19) tick();
        chk("t5_done_19", t_done, 0);
        chk("t5_cyc_19", t_cyc, 19);
        tick();
        chk("t5_done", t_done, 1);
        chk("t5_code", t_code, 3);
        chk("t5_pass", t_pass, 0);
        chk("t5_cyc", t_cyc, 20);
        tick();
        chk("t5_cyc_frozen", t_cyc, 20);

        // T5b: expected store on the timeout edge wins
        rst_to = 1'b0;
        tick();
        rst_to = 1'b1;
        do_arm();
        repeat (19) tick();
        store(32'd84, 32'd7);
        chk("t5b_pass", t_pass, 1);
        chk("t5b_code", t_code, 0);
        chk("t5b_idx", t_idx, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
